// File: rtl/frogger_pkg.sv
// Shared definitions for the Frogger obstacle engine: FSM encoding, tile geometry
// and the initial car placement rule.
package frogger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_HIT     = 2'd2
    } state_t;

    localparam int TILE_W            = 6;
    localparam int PF_GAME_WIDTH     = 14;
    localparam int PF_GAME_HEIGHT    = 15;
    localparam int PF_FIRST_LANE_ROW = 7;
    localparam int PF_NUM_LANES      = 5;
    localparam int PF_LAST_LANE_ROW  = PF_FIRST_LANE_ROW + PF_NUM_LANES - 1;

    // Cars are spread evenly across the lane, and each lane is skewed by 3 tiles.
    function automatic logic [TILE_W-1:0] car_init_x(input int car, input int lane,
                                                     input int width, input int cars);
        return TILE_W'((car * (width / cars) + 3 * lane) % width);
    endfunction

endpackage

// File: rtl/frogger_lane.sv
// One road lane: step counter, car X registers with wrap-around, and tile match
// outputs used by the top for drawing and collision.
module frogger_lane
    import frogger_pkg::*;
#(
    parameter int CARS       = 2,
    parameter int GAME_WIDTH = 14,
    parameter int LANE       = 0,
    parameter bit DIR_LEFT   = 1'b0,
    parameter int CNT_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reload,
    input  logic              clr_cnt,
    input  logic              step_tick,
    input  logic [CNT_W-1:0]  period,
    input  logic [TILE_W-1:0] draw_col,
    input  logic [TILE_W-1:0] frog_x,
    output logic              draw_match,
    output logic              frog_match
);

    localparam logic [TILE_W-1:0] X_MAX = TILE_W'(GAME_WIDTH - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d, period_m1;
    logic [TILE_W-1:0] car_x_q [CARS];
    logic [TILE_W-1:0] car_x_d [CARS];

    function automatic logic [TILE_W-1:0] next_x(input logic [TILE_W-1:0] x);
        if (DIR_LEFT)
            return (x == '0) ? X_MAX : x - TILE_W'(1);
        else
            return (x == X_MAX) ? '0 : x + TILE_W'(1);
    endfunction

    assign period_m1 = period - CNT_W'(1);

    // ">=" also covers a period that shrank below the current count.
    always_comb begin
        cnt_d   = cnt_q;
        car_x_d = car_x_q;
        if (reload) begin
            cnt_d = '0;
            for (int k = 0; k < CARS; k++)
                car_x_d[k] = car_init_x(k, LANE, GAME_WIDTH, CARS);
        end else if (clr_cnt) begin
            cnt_d = '0;
        end else if (step_tick) begin
            if (cnt_q >= period_m1) begin
                cnt_d = '0;
                for (int k = 0; k < CARS; k++)
                    car_x_d[k] = next_x(car_x_q[k]);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int k = 0; k < CARS; k++)
                car_x_q[k] <= car_init_x(k, LANE, GAME_WIDTH, CARS);
        end else begin
            cnt_q   <= cnt_d;
            car_x_q <= car_x_d;
        end
    end

    always_comb begin
        draw_match = 1'b0;
        frog_match = 1'b0;
        for (int k = 0; k < CARS; k++) begin
            if (car_x_q[k] == draw_col) draw_match = 1'b1;
            if (car_x_q[k] == frog_x)   frog_match = 1'b1;
        end
    end

endmodule

// File: rtl/frogger_traffic_engine.sv
// Obstacle engine: per-lane car movement, level-scaled step period, hit detection
// with a post-hit freeze, and a registered car-draw output.
module frogger_traffic_engine
    import frogger_pkg::*;
#(
    parameter int                   NUM_LANES      = PF_NUM_LANES,
    parameter int                   CARS_PER_LANE  = 2,
    parameter int                   GAME_WIDTH     = PF_GAME_WIDTH,
    parameter int                   FIRST_LANE_ROW = PF_FIRST_LANE_ROW,
    parameter logic [NUM_LANES-1:0] LANE_DIR       = NUM_LANES'(5'b01010),
    parameter int                   BASE_FRAMES    = 16,
    parameter int                   SPEEDUP_STEP   = 2,
    parameter int                   MIN_FRAMES     = 2,
    parameter int                   HIT_FRAMES     = 30
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Frame_Tick,
    input  logic       i_Enable,
    input  logic [3:0] i_Level,
    input  logic [4:0] i_Col_Count_Div,
    input  logic [4:0] i_Row_Count_Div,
    input  logic [5:0] i_Frogger_X,
    input  logic [5:0] i_Frogger_Y,
    output logic       o_Draw_Car,
    output logic       o_Collided,
    output logic       o_Hit_Active
);

    localparam int                CNT_W    = $clog2(BASE_FRAMES + 1);
    localparam int                HCNT_W   = $clog2(HIT_FRAMES + 1);
    localparam logic [HCNT_W-1:0] HIT_LAST = HCNT_W'(HIT_FRAMES - 1);

    // Signed so that high levels go negative and clamp instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_period(input logic [3:0] level);
        logic signed [11:0] base_s, step_s, lvl_s, min_s, raw_s;
        base_s = 12'(BASE_FRAMES);
        step_s = 12'(SPEEDUP_STEP);
        min_s  = 12'(MIN_FRAMES);
        lvl_s  = signed'({8'd0, level});
        raw_s  = base_s - lvl_s * step_s;
        if (raw_s < min_s) raw_s = min_s;
        return raw_s[CNT_W-1:0];
    endfunction

    state_t              state_q, state_d;
    logic [HCNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic                collided_q, collided_d;
    logic                hit_active_q, hit_active_d;
    logic                draw_q, draw_d;
    logic                reload, clr_cnt, step_tick, hit_w;
    logic [CNT_W-1:0]    period;
    logic [TILE_W-1:0]   col_ext, row_ext;
    logic [NUM_LANES-1:0] lane_draw, lane_frog;

    assign period  = sat_period(i_Level);
    assign col_ext = TILE_W'(i_Col_Count_Div);
    assign row_ext = TILE_W'(i_Row_Count_Div);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        frogger_lane #(
            .CARS       (CARS_PER_LANE),
            .GAME_WIDTH (GAME_WIDTH),
            .LANE       (l),
            .DIR_LEFT   (LANE_DIR[l]),
            .CNT_W      (CNT_W)
        ) u_lane (
            .clk        (i_Clk),
            .rst        (i_Rst),
            .reload     (reload),
            .clr_cnt    (clr_cnt),
            .step_tick  (step_tick),
            .period     (period),
            .draw_col   (col_ext),
            .frog_x     (i_Frogger_X),
            .draw_match (lane_draw[l]),
            .frog_match (lane_frog[l])
        );
    end

    // Matches use the current car registers, i.e. positions before any step this cycle.
    always_comb begin
        hit_w  = 1'b0;
        draw_d = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (i_Frogger_Y == TILE_W'(FIRST_LANE_ROW + l) && lane_frog[l]) hit_w  = 1'b1;
            if (row_ext == TILE_W'(FIRST_LANE_ROW + l) && lane_draw[l])     draw_d = 1'b1;
        end
        if (col_ext >= TILE_W'(GAME_WIDTH)) draw_d = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        collided_d = 1'b0;
        reload     = 1'b0;
        clr_cnt    = 1'b0;
        step_tick  = 1'b0;
        if (!i_Enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUNNING;
                    reload  = 1'b1;
                end
                ST_RUNNING: begin
                    if (hit_w) begin
                        state_d    = ST_HIT;
                        collided_d = 1'b1;
                        hit_cnt_d  = '0;
                    end else if (i_Frame_Tick) begin
                        step_tick = 1'b1;
                    end
                end
                ST_HIT: begin
                    if (i_Frame_Tick) begin
                        if (hit_cnt_q == HIT_LAST) begin
                            state_d   = ST_RUNNING;
                            clr_cnt   = 1'b1;
                            hit_cnt_d = '0;
                        end else begin
                            hit_cnt_d = hit_cnt_q + HCNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        hit_active_d = (state_d == ST_HIT);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q      <= ST_IDLE;
            hit_cnt_q    <= '0;
            collided_q   <= 1'b0;
            hit_active_q <= 1'b0;
            draw_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hit_cnt_q    <= hit_cnt_d;
            collided_q   <= collided_d;
            hit_active_q <= hit_active_d;
            draw_q       <= draw_d;
        end
    end

    assign o_Draw_Car   = draw_q;
    assign o_Collided   = collided_q;
    assign o_Hit_Active = hit_active_q;

endmodule
